// File: rtl/sprite_blit_ctrl.sv
// sprite_blit_ctrl: streams a 28x30 sprite from synchronous sprite RAM to the VGA plot port.
// Ports:
//   clk_i, resetn_i        clock, asynchronous active-low reset
//   start_i, x0_i, y0_i    draw request and sprite origin (sampled only when idle)
//   erase_i                (SPRITE_ERASE_EN only) plot BG_COLOUR instead of stored colour
//   rom_addr_o/rom_data_i  sprite RAM read port, data valid one cycle after address
//   vga_x_o/vga_y_o/vga_colour_o/plot_o  registered plot interface
//   busy_o, done_o         draw in progress / one-cycle completion pulse
// Optional feature macro: SPRITE_ERASE_EN.
module sprite_blit_ctrl #(
    parameter int SPR_W    = 28,
    parameter int SPR_H    = 30,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int COLOUR_W = 3
`ifdef SPRITE_ERASE_EN
    ,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
`endif
) (
    input  logic                clk_i,
    input  logic                resetn_i,
    input  logic                start_i,
`ifdef SPRITE_ERASE_EN
    input  logic                erase_i,
`endif
    input  logic [7:0]          x0_i,
    input  logic [6:0]          y0_i,
    output logic [9:0]          rom_addr_o,
    input  logic [15:0]         rom_data_i,
    output logic [7:0]          vga_x_o,
    output logic [6:0]          vga_y_o,
    output logic [COLOUR_W-1:0] vga_colour_o,
    output logic                plot_o,
    output logic                busy_o,
    output logic                done_o
);
    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);
    localparam logic [9:0]    LAST_ADDR = 10'(SPR_W * SPR_H - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(SPR_W - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(SPR_H - 1);

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

    state_t              state_q, state_d;
    logic [7:0]          x0_q, x0_d;
    logic [6:0]          y0_q, y0_d;
    logic [9:0]          addr_q, addr_d;
    logic [CW-1:0]       col_q, col_d, pcol_q, pcol_d;
    logic [RW-1:0]       row_q, row_d, prow_q, prow_d;
    logic [7:0]          vx_q, vx_d;
    logic [6:0]          vy_q, vy_d;
    logic [COLOUR_W-1:0] vc_q, vc_d;
    logic                plot_q, plot_d, busy_q, busy_d, done_q, done_d;
    logic [8:0]          sum_x;
    logic [7:0]          sum_y;
    logic                in_bounds, cnt_end, pipe_end;
    logic [COLOUR_W-1:0] pix_colour;
    logic                unused_bits;

    // Sums are one bit wider than the screen coordinates so off-screen pixels
    // are detected instead of wrapping back onto the visible area.
    assign sum_x     = {1'b0, x0_q} + 9'(pcol_q);
    assign sum_y     = {1'b0, y0_q} + 8'(prow_q);
    assign in_bounds = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
    assign cnt_end   = (col_q == LAST_COL) && (row_q == LAST_ROW);
    assign pipe_end  = (pcol_q == LAST_COL) && (prow_q == LAST_ROW);
    assign unused_bits = ^rom_data_i[15-COLOUR_W:1];

`ifdef SPRITE_ERASE_EN
    logic erase_q, erase_d;
    assign pix_colour = erase_q ? BG_COLOUR : rom_data_i[15 -: COLOUR_W];
`else
    assign pix_colour = rom_data_i[15 -: COLOUR_W];
`endif

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            pcol_q  <= '0;
            prow_q  <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            vc_q    <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPRITE_ERASE_EN
            erase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pcol_q  <= pcol_d;
            prow_q  <= prow_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            vc_q    <= vc_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SPRITE_ERASE_EN
            erase_q <= erase_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        addr_d  = addr_q;
        col_d   = col_q;
        row_d   = row_q;
        pcol_d  = pcol_q;
        prow_d  = prow_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        vc_d    = vc_q;
        plot_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SPRITE_ERASE_EN
        erase_d = erase_q;
`endif
        case (state_q)
            IDLE: if (start_i) begin
                x0_d    = x0_i;
                y0_d    = y0_i;
                addr_d  = '0;
                col_d   = '0;
                row_d   = '0;
                busy_d  = 1'b1;
                state_d = FETCH;
`ifdef SPRITE_ERASE_EN
                erase_d = erase_i;
`endif
            end
            FETCH, STREAM: begin
                // (col,row) track the address being issued; the pipeline copy
                // tracks the word arriving on rom_data_i one cycle later.
                pcol_d = col_q;
                prow_d = row_q;
                addr_d = (addr_q == LAST_ADDR) ? addr_q : addr_q + 10'd1;
                if (!cnt_end) begin
                    col_d = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
                    row_d = (col_q == LAST_COL) ? row_q + 1'b1 : row_q;
                end
                state_d = STREAM;
                if (state_q == STREAM) begin
                    plot_d  = rom_data_i[0] & in_bounds;
                    vx_d    = sum_x[7:0];
                    vy_d    = sum_y[6:0];
                    vc_d    = pix_colour;
                    state_d = pipe_end ? DONE : STREAM;
                end
            end
            DONE: begin
                // First DONE cycle lets the last pixel's plot go out; the second
                // carries the done pulse and releases busy.
                done_d  = ~done_q;
                busy_d  = ~done_q;
                state_d = done_q ? IDLE : DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rom_addr_o   = addr_q;
    assign vga_x_o      = vx_q;
    assign vga_y_o      = vy_q;
    assign vga_colour_o = vc_q;
    assign plot_o       = plot_q;
    assign done_o       = done_q;
    // busy rises in the same cycle the start is accepted.
    assign busy_o       = busy_q | ((state_q == IDLE) && start_i && resetn_i);
endmodule

// File: tb/tb_sprite_blit_ctrl.sv
// tb_sprite_blit_ctrl: scoreboard bench for sprite_blit_ctrl with a pixel-level reference model.
module tb_sprite_blit_ctrl;
    localparam int W = 28;
    localparam int H = 30;
    localparam int N = W * H;

    logic        clk = 1'b0, resetn = 1'b0, start = 1'b0, erase = 1'b0;
    logic [7:0]  x0 = '0;
    logic [6:0]  y0 = '0;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        plot, busy, done;
    logic [15:0] mem [N];

    typedef struct {int c; int x; int y; int col;} ev_t;
    ev_t pq[$];
    int  dq[$];
    int  cyc = 0, checks = 0, failures = 0, plots_seen = 0;
    int  busy_lo = -1, busy_hi = -1;

    sprite_blit_ctrl dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .start_i      (start),
`ifdef SPRITE_ERASE_EN
        .erase_i      (erase),
`endif
        .x0_i         (x0),
        .y0_i         (y0),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .vga_x_o      (vga_x),
        .vga_y_o      (vga_y),
        .vga_colour_o (vga_colour),
        .plot_o       (plot),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= (rom_addr < 10'(N)) ? mem[rom_addr] : 16'hdead;

    function automatic void chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin : monitor
        ev_t e;
        if (plot) begin
            plots_seen++;
            if (pq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_plot: got plot at (%0d,%0d) expected none (cycle %0d)", vga_x, vga_y, cyc);
            end else begin
                e = pq.pop_front();
                chk("plot_cycle", cyc, e.c);
                chk("plot_x", int'(vga_x), e.x);
                chk("plot_y", int'(vga_y), e.y);
                chk("plot_colour", int'(vga_colour), e.col);
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done expected none (cycle %0d)", cyc);
            end else chk("done_cycle", cyc, dq.pop_front());
        end
        chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
        if (rom_addr > 10'(N - 1)) chk("rom_addr_range", int'(rom_addr), N - 1);
    end

    // Reference: pixel a sits at (a mod W, a div W); drawn if opaque and on screen,
    // visible 3 cycles after the start cycle plus one cycle per word.
    task automatic issue(input int x, input int y, input logic er, output int c0, output int n);
        logic ee;
`ifdef SPRITE_ERASE_EN
        ee = er;
`else
        ee = 1'b0;
`endif
        n = 0;
        @(posedge clk); #1;
        x0 = 8'(x); y0 = 7'(y); erase = er; start = 1'b1; c0 = cyc;
        for (int a = 0; a < N; a++) begin
            int cx = x + a % W;
            int cy = y + a / W;
            if (mem[a][0] && cx < 160 && cy < 120) begin
                pq.push_back('{c0 + 3 + a, cx, cy, ee ? 0 : int'(mem[a][15:13])});
                n++;
            end
        end
        dq.push_back(c0 + 843);
        busy_lo = c0;
        busy_hi = c0 + 843;
        @(posedge clk); #1;
        start = 1'b0; x0 = 8'($urandom); y0 = 7'($urandom); erase = ~er;
    endtask

    task automatic draw(input int x, input int y, input logic er, input logic stray);
        int c0, n, p0;
        p0 = plots_seen;
        issue(x, y, er, c0, n);
        while (cyc < c0 + 846) begin
            @(posedge clk); #1;
            start = stray && (cyc == c0 + 5 || cyc == c0 + 843);
        end
        start = 1'b0;
        chk("plot_count", plots_seen - p0, n);
        chk("plots_pending", pq.size(), 0);
        chk("done_pending", dq.size(), 0);
    endtask

    task automatic fill(input int mode, input logic [15:0] v);
        for (int a = 0; a < N; a++) begin
            logic [15:0] r = 16'($urandom);
            mem[a] = (mode == 0) ? v : (mode == 1) ? {r[15:1], a[0]} : r;
        end
    endtask

    initial begin
        int c0, n;
        fill(0, 16'h0001);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_vga_x", int'(vga_x), 0);
        chk("rst_vga_y", int'(vga_y), 0);
        chk("rst_colour", int'(vga_colour), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        resetn = 1'b1;

        draw(10, 20, 1'b0, 1'b0);
        fill(1, 16'h0);
        draw(5, 7, 1'b0, 1'b0);
        fill(0, 16'ha001);
        draw(150, 100, 1'b0, 1'b1);
        fill(0, 16'he001);
        draw(40, 50, 1'b1, 1'b0);

        fill(2, 16'h0);
        issue(3, 4, 1'b0, c0, n);
        while (cyc < c0 + 400) begin
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        pq.delete();
        dq.delete();
        busy_lo = -1;
        busy_hi = -1;
        #1;
        chk("midrst_plot", int'(plot), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_rom_addr", int'(rom_addr), 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        fill(0, 16'h6001);
        draw(0, 0, 1'b0, 1'b0);

        repeat (4) begin
            fill(2, 16'h0);
            draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
